sha_k_sequencer: RTL and testbench

Parametrised SHA-2 round-constant source for the hashing datapath in the PUF post-processing chain. It streams the round constants K[0..ROUNDS-1] to the compression core under a valid/ready handshake, and also offers an independent registered random-access read port. One build-time parameter selects SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds). All outputs are registered.

---
 rtl/sha_k_sequencer_if.sv | 32 +++
 rtl/sha_k_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_sha_k_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_k_sequencer_if.sv
// Handshake bundle between the SHA-2 K sequencer and its consumer.
// Stream beats flow slave->master; random-access reads share the bundle.
interface sha_k_sequencer_if #(
   parameter int WORD_W = 32
);
   logic              start;
   logic              abort;
   logic [WORD_W-1:0] k_data;
   logic [6:0]        k_round;
   logic              k_valid;
   logic              k_last;
   logic              k_ready;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [6:0]        rd_addr;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_err;

   modport master (
      output start, abort, k_ready, rd_en, rd_addr,
      input  k_data, k_round, k_valid, k_last,
      input  busy, done, rd_data, rd_valid, rd_err
   );

   modport slave (
      input  start, abort, k_ready, rd_en, rd_addr,
      output k_data, k_round, k_valid, k_last,
      output busy, done, rd_data, rd_valid, rd_err
   );
endinterface

// File: rtl/sha_k_sequencer.sv
// SHA-256/512 round-constant streamer with an independent registered
// random-access read port; both share one combinational K table.
module sha_k_sequencer #(
   parameter int WORD_W = 32
) (
   input logic               clk,
   input logic               rst,
   sha_k_sequencer_if.slave  kbus
);

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha_k_sequencer: WORD_W must be 32 or 64");
   end

   localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
   localparam logic [6:0] NR     = 7'(ROUNDS);
   localparam logic [6:0] LAST   = 7'(ROUNDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [6:0]        idx_q, idx_d;
   logic [WORD_W-1:0] kdata_q, kdata_d;
   logic [6:0]        kround_q, kround_d;
   logic              kvalid_q, kvalid_d;
   logic              klast_q, klast_d;
   logic              done_q, done_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              rerr_q, rerr_d;
   logic              hs;

   function automatic logic [63:0] k512(input logic [6:0] a);
      case (a)
         7'd0:  return 64'h428a2f98d728ae22;
         7'd1:  return 64'h7137449123ef65cd;
         7'd2:  return 64'hb5c0fbcfec4d3b2f;
         7'd3:  return 64'he9b5dba58189dbbc;
         7'd4:  return 64'h3956c25bf348b538;
         7'd5:  return 64'h59f111f1b605d019;
         7'd6:  return 64'h923f82a4af194f9b;
         7'd7:  return 64'hab1c5ed5da6d8118;
         7'd8:  return 64'hd807aa98a3030242;
         7'd9:  return 64'h12835b0145706fbe;
         7'd10: return 64'h243185be4ee4b28c;
         7'd11: return 64'h550c7dc3d5ffb4e2;
         7'd12: return 64'h72be5d74f27b896f;
         7'd13: return 64'h80deb1fe3b1696b1;
         7'd14: return 64'h9bdc06a725c71235;
         7'd15: return 64'hc19bf174cf692694;
         7'd16: return 64'he49b69c19ef14ad2;
         7'd17: return 64'hefbe4786384f25e3;
         7'd18: return 64'h0fc19dc68b8cd5b5;
         7'd19: return 64'h240ca1cc77ac9c65;
         7'd20: return 64'h2de92c6f592b0275;
         7'd21: return 64'h4a7484aa6ea6e483;
         7'd22: return 64'h5cb0a9dcbd41fbd4;
         7'd23: return 64'h76f988da831153b5;
         7'd24: return 64'h983e5152ee66dfab;
         7'd25: return 64'ha831c66d2db43210;
         7'd26: return 64'hb00327c898fb213f;
         7'd27: return 64'hbf597fc7beef0ee4;
         7'd28: return 64'hc6e00bf33da88fc2;
         7'd29: return 64'hd5a79147930aa725;
         7'd30: return 64'h06ca6351e003826f;
         7'd31: return 64'h142929670a0e6e70;
         7'd32: return 64'h27b70a8546d22ffc;
         7'd33: return 64'h2e1b21385c26c926;
         7'd34: return 64'h4d2c6dfc5ac42aed;
         7'd35: return 64'h53380d139d95b3df;
         7'd36: return 64'h650a73548baf63de;
         7'd37: return 64'h766a0abb3c77b2a8;
         7'd38: return 64'h81c2c92e47edaee6;
         7'd39: return 64'h92722c851482353b;
         7'd40: return 64'ha2bfe8a14cf10364;
         7'd41: return 64'ha81a664bbc423001;
         7'd42: return 64'hc24b8b70d0f89791;
         7'd43: return 64'hc76c51a30654be30;
         7'd44: return 64'hd192e819d6ef5218;
         7'd45: return 64'hd69906245565a910;
         7'd46: return 64'hf40e35855771202a;
         7'd47: return 64'h106aa07032bbd1b8;
         7'd48: return 64'h19a4c116b8d2d0c8;
         7'd49: return 64'h1e376c085141ab53;
         7'd50: return 64'h2748774cdf8eeb99;
         7'd51: return 64'h34b0bcb5e19b48a8;
         7'd52: return 64'h391c0cb3c5c95a63;
         7'd53: return 64'h4ed8aa4ae3418acb;
         7'd54: return 64'h5b9cca4f7763e373;
         7'd55: return 64'h682e6ff3d6b2b8a3;
         7'd56: return 64'h748f82ee5defb2fc;
         7'd57: return 64'h78a5636f43172f60;
         7'd58: return 64'h84c87814a1f0ab72;
         7'd59: return 64'h8cc702081a6439ec;
         7'd60: return 64'h90befffa23631e28;
         7'd61: return 64'ha4506cebde82bde9;
         7'd62: return 64'hbef9a3f7b2c67915;
         7'd63: return 64'hc67178f2e372532b;
         7'd64: return 64'hca273eceea26619c;
         7'd65: return 64'hd186b8c721c0c207;
         7'd66: return 64'heada7dd6cde0eb1e;
         7'd67: return 64'hf57d4f7fee6ed178;
         7'd68: return 64'h06f067aa72176fba;
         7'd69: return 64'h0a637dc5a2c898a6;
         7'd70: return 64'h113f9804bef90dae;
         7'd71: return 64'h1b710b35131c471b;
         7'd72: return 64'h28db77f523047d84;
         7'd73: return 64'h32caab7b40c72493;
         7'd74: return 64'h3c9ebe0a15c9bebc;
         7'd75: return 64'h431d67c49c100d4c;
         7'd76: return 64'h4cc5d4becb3e42b6;
         7'd77: return 64'h597f299cfc657e2a;
         7'd78: return 64'h5fcb6fab3ad6faec;
         7'd79: return 64'h6c44198c4a475817;
         default: return 64'h0;
      endcase
   endfunction

   // SHA-256 K is the upper half of the first 64 SHA-512 entries.
   function automatic logic [WORD_W-1:0] word(input logic [6:0] a);
      return WORD_W'(k512(a) >> (64 - WORD_W));
   endfunction

   assign hs = kvalid_q & kbus.k_ready;

   // idx_q is held at 0 whenever IDLE, so it doubles as the stream address.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      kdata_d  = kdata_q;
      kround_d = kround_q;
      kvalid_d = kvalid_q;
      klast_d  = klast_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (kbus.start && !kbus.abort) begin
               kdata_d  = word(idx_q);
               kround_d = 7'd0;
               kvalid_d = 1'b1;
               klast_d  = 1'b0;
               idx_d    = 7'd1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (kbus.abort) begin
               kvalid_d = 1'b0;
               klast_d  = 1'b0;
               idx_d    = 7'd0;
               state_d  = IDLE;
            end else if (hs) begin
               if (kround_q == LAST) begin
                  kvalid_d = 1'b0;
                  klast_d  = 1'b0;
                  idx_d    = 7'd0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  kdata_d  = word(idx_q);
                  kround_d = idx_q;
                  klast_d  = (idx_q == LAST);
                  idx_d    = idx_q + 7'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      rvalid_d = kbus.rd_en;
      rerr_d   = 1'b0;
      rdata_d  = rdata_q;
      if (kbus.rd_en) begin
         rerr_d  = (kbus.rd_addr >= NR);
         rdata_d = (kbus.rd_addr < NR) ? word(kbus.rd_addr) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         kdata_q  <= '0;
         kround_q <= '0;
         kvalid_q <= 1'b0;
         klast_q  <= 1'b0;
         done_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         kdata_q  <= kdata_d;
         kround_q <= kround_d;
         kvalid_q <= kvalid_d;
         klast_q  <= klast_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
      end
   end

   assign kbus.k_data   = kdata_q;
   assign kbus.k_round  = kround_q;
   assign kbus.k_valid  = kvalid_q;
   assign kbus.k_last   = klast_q;
   assign kbus.busy     = (state_q == RUN);
   assign kbus.done     = done_q;
   assign kbus.rd_data  = rdata_q;
   assign kbus.rd_valid = rvalid_q;
   assign kbus.rd_err   = rerr_q;

endmodule

// File: tb/tb_sha_k_sequencer.sv
// Scoreboard bench: a SHA-256 and a SHA-512 instance driven in lockstep,
// expected beats/reads queued at stimulus time and popped by a monitor.
module tb_sha_k_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic start, abort, k_ready, rd_en;
   logic [6:0] rd_addr;

   always #5 clk = ~clk;

   sha_k_sequencer_if #(.WORD_W(32)) b32 ();
   sha_k_sequencer_if #(.WORD_W(64)) b64 ();

   assign b32.start = start;   assign b64.start = start;
   assign b32.abort = abort;   assign b64.abort = abort;
   assign b32.k_ready = k_ready; assign b64.k_ready = k_ready;
   assign b32.rd_en = rd_en;   assign b64.rd_en = rd_en;
   assign b32.rd_addr = rd_addr; assign b64.rd_addr = rd_addr;

   sha_k_sequencer #(.WORD_W(32)) dut32 (.clk(clk), .rst(rst), .kbus(b32));
   sha_k_sequencer #(.WORD_W(64)) dut64 (.clk(clk), .rst(rst), .kbus(b64));

   logic [63:0] kd [2];
   logic [63:0] rdd [2];
   logic [6:0]  kr [2];
   logic kv [2], kl [2], bz [2], dn [2], rv [2], re [2];

   assign kd[0] = {32'h0, b32.k_data};  assign kd[1] = b64.k_data;
   assign rdd[0] = {32'h0, b32.rd_data}; assign rdd[1] = b64.rd_data;
   assign kr[0] = b32.k_round;  assign kr[1] = b64.k_round;
   assign kv[0] = b32.k_valid;  assign kv[1] = b64.k_valid;
   assign kl[0] = b32.k_last;   assign kl[1] = b64.k_last;
   assign bz[0] = b32.busy;     assign bz[1] = b64.busy;
   assign dn[0] = b32.done;     assign dn[1] = b64.done;
   assign rv[0] = b32.rd_valid; assign rv[1] = b64.rd_valid;
   assign re[0] = b32.rd_err;   assign re[1] = b64.rd_err;

   // FIPS 180-4 SHA-512 round constants.
   localparam logic [63:0] G [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   typedef struct packed {
      logic [63:0] d;
      logic [6:0]  r;
   } beat_t;

   typedef struct packed {
      logic [63:0] d;
      logic        e;
   } rd_t;

   beat_t kq [2][$];
   rd_t   rq [2][$];

   int cmp = 0;
   int mis = 0;
   int dcnt [2] = '{0, 0};
   logic last_acc [2];
   logic pv [2];
   logic [63:0] pd [2];
   logic [6:0]  pr [2];

   function automatic int rounds(input int d);
      return (d == 0) ? 64 : 80;
   endfunction

   function automatic logic [63:0] kexp(input int d, input int i);
      logic [63:0] g;
      if (i >= rounds(d)) return 64'h0;
      g = G[i];
      return (d == 0) ? {32'h0, g[63:32]} : g;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm, input int act, input int exp);
      cmp++;
      mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream();
      for (int d = 0; d < 2; d++) begin
         kq[d].delete();
         for (int i = 0; i < rounds(d); i++)
            kq[d].push_back('{d: kexp(d, i), r: 7'(i)});
      end
   endtask

   task automatic push_rd(input int a);
      for (int d = 0; d < 2; d++)
         rq[d].push_back('{d: kexp(d, a), e: (a >= rounds(d))});
   endtask

   task automatic flush();
      for (int d = 0; d < 2; d++) begin
         kq[d].delete();
         rq[d].delete();
      end
   endtask

   task automatic chk_zero();
      for (int d = 0; d < 2; d++) begin
         chk("rst_k_data", kd[d], 0);
         chk("rst_k_round", 64'(kr[d]), 0);
         chk("rst_k_valid", 64'(kv[d]), 0);
         chk("rst_k_last", 64'(kl[d]), 0);
         chk("rst_busy", 64'(bz[d]), 0);
         chk("rst_done", 64'(dn[d]), 0);
         chk("rst_rd_data", rdd[d], 0);
         chk("rst_rd_valid", 64'(rv[d]), 0);
         chk("rst_rd_err", 64'(re[d]), 0);
      end
   endtask

   task automatic wait_drained(input int budget);
      int n = 0;
      while ((kq[0].size() != 0 || kq[1].size() != 0 ||
              rq[0].size() != 0 || rq[1].size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) fail("drain_timeout", n, budget);
      tick();
      tick();
   endtask

   task automatic wait_round(input int r);
      int n = 0;
      while (kr[0] != 7'(r) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) fail("round_timeout", n, 100);
   endtask

   // Monitor: samples on the falling edge, between input updates and the next rising edge.
   always @(negedge clk) begin
      beat_t b;
      rd_t   q;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            last_acc[d] = 1'b0;
            pv[d] = 1'b0;
         end else begin
            if (last_acc[d]) begin
               chk("done_pulse", 64'(dn[d]), 1);
               chk("busy_after_last", 64'(bz[d]), 0);
               chk("valid_after_last", 64'(kv[d]), 0);
               last_acc[d] = 1'b0;
            end else if (dn[d]) begin
               fail("unexpected_done", d, -1);
            end
            if (dn[d]) dcnt[d]++;
            if (pv[d]) begin
               chk("hold_k_data", kd[d], pd[d]);
               chk("hold_k_round", 64'(kr[d]), 64'(pr[d]));
            end
            if (kv[d])
               chk("k_last", 64'(kl[d]), 64'(kr[d] == 7'(rounds(d) - 1)));
            if (kv[d] && k_ready && !abort) begin
               if (kq[d].size() == 0) begin
                  fail("unexpected_beat", int'(kr[d]), -1);
               end else begin
                  b = kq[d].pop_front();
                  chk("k_data", kd[d], b.d);
                  chk("k_round", 64'(kr[d]), 64'(b.r));
                  if (b.r == 7'(rounds(d) - 1)) last_acc[d] = 1'b1;
               end
            end
            pv[d] = kv[d] & ~k_ready & ~abort;
            pd[d] = kd[d];
            pr[d] = kr[d];
            if (rv[d]) begin
               if (rq[d].size() == 0) begin
                  fail("unexpected_rd_valid", d, -1);
               end else begin
                  q = rq[d].pop_front();
                  chk("rd_data", rdd[d], q.d);
                  chk("rd_err", 64'(re[d]), 64'(q.e));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_list [5] = '{5, 64, 79, 80, 0};
      int dc0, dc1;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      k_ready = 1'b0;
      rd_en = 1'b0;
      rd_addr = 7'd0;
      #3;
      chk_zero();
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Full streams, k_ready held high, plus an ignored start mid-run.
      push_stream();
      start = 1'b1;
      k_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("first_beat32", kd[0], 64'h428a2f98);
      chk("first_beat64", kd[1], 64'h428a2f98d728ae22);
      chk("busy_run", 64'(bz[0]), 1);
      repeat (20) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_drained(200);

      // Random backpressure with concurrent random-access reads.
      push_stream();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 400 && (kq[0].size() != 0 || kq[1].size() != 0); c++) begin
         k_ready = 1'($urandom_range(0, 1));
         if (c >= 5 && c < 10) begin
            rd_en = 1'b1;
            rd_addr = 7'(rd_list[c-5]);
            push_rd(rd_list[c-5]);
         end else begin
            rd_en = 1'b0;
         end
         tick();
      end
      rd_en = 1'b0;
      k_ready = 1'b1;
      wait_drained(200);

      // Abort coinciding with a handshake at round 10.
      push_stream();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_round(10);
      dc0 = dcnt[0];
      dc1 = dcnt[1];
      abort = 1'b1;
      tick();
      abort = 1'b0;
      flush();
      chk("abort_valid32", 64'(kv[0]), 0);
      chk("abort_valid64", 64'(kv[1]), 0);
      chk("abort_busy32", 64'(bz[0]), 0);
      repeat (5) tick();
      chk("abort_no_done32", 64'(dcnt[0]), 64'(dc0));
      chk("abort_no_done64", 64'(dcnt[1]), 64'(dc1));
      push_stream();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_k0_32", kd[0], 64'h428a2f98);
      chk("restart_round", 64'(kr[1]), 0);
      wait_drained(200);

      // start together with abort in IDLE is ignored.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_valid32", 64'(kv[0]), 0);
      chk("start_abort_valid64", 64'(kv[1]), 0);
      tick();
      chk("start_abort_busy", 64'(bz[1]), 0);

      // Asynchronous reset mid-stream at round 30.
      push_stream();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_round(30);
      rst = 1'b1;
      #1;
      chk_zero();
      flush();
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("post_rst_valid32", 64'(kv[0]), 0);
      chk("post_rst_valid64", 64'(kv[1]), 0);
      chk("post_rst_busy64", 64'(bz[1]), 0);

      push_stream();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_drained(200);

      chk("done_count32", 64'(dcnt[0]), 4);
      chk("done_count64", 64'(dcnt[1]), 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

endmodule
